game_sequencer: RTL

Parametrised top-level game controller for the whack-a-mole design. It sequences IDLE → COUNTDOWN → PLAYING → GAME_OVER and adds a PAUSED state. It owns the countdown and game-time counters, driven by an external 1 Hz tick pulse. It latches difficulty, tracks the session high score, and drives the enable/clear strobes for the score counter and mole controller plus the 7-segment display value.

---
 rtl/game_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - whack-a-mole game sequencer: countdown/play/pause/game-over control with timers
// Optional HIGH_SCORE_EN compiles in the session high-score register.
module game_sequencer #(
  parameter int COUNTDOWN_SEC = 5,
  parameter int GAME_SEC      = 30,
  parameter int TIME_W        = 6,
  parameter int SCORE_W       = 8,
  parameter int DIFF_W        = 2,
  parameter int NUM_LEVELS    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_clear_score,
  input  logic               btn_difficulty_pulse,
  input  logic [DIFF_W-1:0]  difficulty_level_input,
  input  logic [SCORE_W-1:0] score,
  output logic               enable_score,
  output logic               clear_score,
  output logic               enable_mole_ctrl,
  output logic [DIFF_W-1:0]  difficulty_level,
  output logic [TIME_W-1:0]  time_remaining,
  output logic [2:0]         state_out,
  output logic               game_over_pulse,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high_score,
  output logic [SCORE_W-1:0] display_value
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COUNTDOWN = 3'd1;
  localparam logic [2:0] S_PLAYING   = 3'd2;
  localparam logic [2:0] S_PAUSED    = 3'd3;
  localparam logic [2:0] S_GAME_OVER = 3'd4;

  localparam logic [TIME_W-1:0] CD_LOAD   = TIME_W'(COUNTDOWN_SEC);
  localparam logic [TIME_W-1:0] GAME_LOAD = TIME_W'(GAME_SEC);
  localparam logic [DIFF_W:0]   LVL_MAX   = (DIFF_W+1)'(NUM_LEVELS - 1);

  logic [2:0]        state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [DIFF_W-1:0] diff_q;
  logic              go_pulse_q, clr_q;
  logic              enter_cd, enter_go, diff_en;
  logic [SCORE_W-1:0] hs_value;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Priority inside each state: start, then phase expiry, then pause.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    case (state_q)
      S_IDLE: begin
        if (btn_start) begin
          state_d = S_COUNTDOWN;
          time_d  = CD_LOAD;
        end
      end
      S_COUNTDOWN: begin
        if (btn_start) begin
          time_d = CD_LOAD;
        end else if (tick_1hz) begin
          if (time_q == TIME_W'(1)) begin
            state_d = S_PLAYING;
            time_d  = GAME_LOAD;
          end else begin
            time_d = time_q - TIME_W'(1);
          end
        end
      end
      S_PLAYING: begin
        if (btn_start) begin
          state_d = S_COUNTDOWN;
          time_d  = CD_LOAD;
        end else if (tick_1hz && time_q == TIME_W'(1)) begin
          state_d = S_GAME_OVER;
          time_d  = '0;
        end else begin
          if (tick_1hz) time_d = time_q - TIME_W'(1);
          if (btn_pause) state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (btn_start) begin
          state_d = S_COUNTDOWN;
          time_d  = CD_LOAD;
        end else if (btn_pause) begin
          state_d = S_PLAYING;
        end
      end
      S_GAME_OVER: begin
        if (btn_start) begin
          state_d = S_COUNTDOWN;
          time_d  = CD_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
        time_d  = '0;
      end
    endcase
  end

  assign enter_cd = (state_d == S_COUNTDOWN) && ((state_q != S_COUNTDOWN) || btn_start);
  assign enter_go = (state_q == S_PLAYING) && (state_d == S_GAME_OVER);
  assign diff_en  = btn_difficulty_pulse && ((state_q == S_IDLE) || (state_q == S_GAME_OVER));

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q     <= '0;
      diff_q     <= '0;
      go_pulse_q <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      time_q     <= time_d;
      go_pulse_q <= enter_go;
      clr_q      <= enter_cd || btn_clear_score;
      if (diff_en) begin
        if ({1'b0, difficulty_level_input} > LVL_MAX) diff_q <= LVL_MAX[DIFF_W-1:0];
        else                                          diff_q <= difficulty_level_input;
      end
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] hs_q;
  logic               new_hs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q     <= '0;
      new_hs_q <= 1'b0;
    end else if (enter_go) begin
      if (score > hs_q) begin
        hs_q     <= score;
        new_hs_q <= 1'b1;
      end else begin
        new_hs_q <= 1'b0;
      end
    end else if (state_q == S_GAME_OVER && state_d != S_GAME_OVER) begin
      new_hs_q <= 1'b0;
    end
  end

  assign hs_value       = hs_q;
  assign new_high_score = new_hs_q;
`else
  assign hs_value       = '0;
  assign new_high_score = 1'b0;
`endif

  always_comb begin
    enable_score     = (state_q == S_PLAYING);
    enable_mole_ctrl = (state_q == S_PLAYING);
    clear_score      = (state_q == S_IDLE) || clr_q;
    state_out        = state_q;
    time_remaining   = time_q;
    difficulty_level = diff_q;
    game_over_pulse  = go_pulse_q;
    high_score       = hs_value;
    case (state_q)
      S_IDLE:                            display_value = hs_value;
      S_COUNTDOWN:                       display_value = SCORE_W'(time_q);
      S_PLAYING, S_PAUSED, S_GAME_OVER:  display_value = score;
      default:                           display_value = '0;
    endcase
  end

endmodule
